// File: rtl/light_interval_timer_if.sv
// ---------------------------------------------------------------------------
// light_interval_timer_if
//
// Purpose:
//   Bundles the request, programming and status signals exchanged between the
//   traffic-light controller and its interval timer.
//
// Signals:
//   start_timer     controller -> timer  one-cycle request to start an interval
//   interval        controller -> timer  00=tBASE 01=tEXT 10=tYEL 11=2*tBASE
//   Prog_Sync       controller -> timer  one-cycle parameter write strobe
//   Time_Param_Sel  controller -> timer  00=tBASE 01=tEXT 10=tYEL 11=reserved
//   Time_Value      controller -> timer  new value in seconds, 0 = default
//   expired         timer -> controller  one-cycle completion pulse
//   busy            timer -> controller  countdown in progress
//   remaining       timer -> controller  seconds left, for display
//
// Modports:
//   master  the controller side (drives requests, reads status)
//   slave   the timer side (reads requests, drives status)
// ---------------------------------------------------------------------------
interface light_interval_timer_if;

  logic       start_timer;
  logic [1:0] interval;
  logic       Prog_Sync;
  logic [1:0] Time_Param_Sel;
  logic [3:0] Time_Value;
  logic       expired;
  logic       busy;
  logic [4:0] remaining;

  modport master (
    output start_timer,
    output interval,
    output Prog_Sync,
    output Time_Param_Sel,
    output Time_Value,
    input  expired,
    input  busy,
    input  remaining
  );

  modport slave (
    input  start_timer,
    input  interval,
    input  Prog_Sync,
    input  Time_Param_Sel,
    input  Time_Value,
    output expired,
    output busy,
    output remaining
  );

endinterface

// File: rtl/light_interval_timer.sv
// ---------------------------------------------------------------------------
// light_interval_timer
//
// Purpose:
//   Timing responder for the traffic-light controller. On a start request it
//   loads one of four durations (tBASE, tEXT, tYEL or 2*tBASE seconds), counts
//   it down in whole seconds derived from a clock prescaler, and returns a
//   single-cycle expired pulse when the count reaches zero. The three time
//   parameters are programmable through a synchronized write strobe and fall
//   back to their defaults on reset or when programmed with zero.
//
// Parameters:
//   TICKS_PER_SEC  clk cycles per one-second tick
//   DEF_BASE       default tBASE in seconds (1..15)
//   DEF_EXT        default tEXT in seconds (1..15)
//   DEF_YEL        default tYEL in seconds (1..15)
//
// Ports:
//   clk            system clock
//   Reset_Sync_n   synchronous active-low reset
//   tmr            light_interval_timer_if.slave: start/interval requests,
//                  parameter programming, expired/busy/remaining status
// ---------------------------------------------------------------------------
module light_interval_timer #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned DEF_BASE      = 6,
  parameter int unsigned DEF_EXT       = 3,
  parameter int unsigned DEF_YEL       = 2
) (
  input  logic                   clk,
  input  logic                   Reset_Sync_n,
  light_interval_timer_if.slave  tmr
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    BASE_RESET = 4'(DEF_BASE);
  localparam logic [3:0]    EXT_RESET  = 4'(DEF_EXT);
  localparam logic [3:0]    YEL_RESET  = 4'(DEF_YEL);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t        state_q,     state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [4:0]    remaining_q, remaining_d;
  logic          expired_q,   expired_d;
  logic [3:0]    tBase_q,     tBase_d;
  logic [3:0]    tExt_q,      tExt_d;
  logic [3:0]    tYel_q,      tYel_d;

  logic [4:0]    duration;
  logic          secondTick;

  // Decode the requested interval into seconds from the current (pre-write)
  // parameter registers, so a write in the same cycle as a start only
  // affects later starts. 2*tBASE is tBASE shifted left, at most 30.
  always_comb begin
    duration = {1'b0, tBase_q};
    unique case (tmr.interval)
      2'b00:   duration = {1'b0, tBase_q};
      2'b01:   duration = {1'b0, tExt_q};
      2'b10:   duration = {1'b0, tYel_q};
      default: duration = {tBase_q, 1'b0};
    endcase
  end

  // A one-second tick occurs on the cycle the prescaler sits at its last
  // value; the prescaler then wraps to zero.
  always_comb begin
    secondTick = (prescaler_q == TICK_LAST);
  end

  // Parameter programming. A write of zero restores that register's default,
  // which keeps every register non-zero and every duration at least 1 s.
  // The reserved selector leaves all registers untouched.
  always_comb begin
    tBase_d = tBase_q;
    tExt_d  = tExt_q;
    tYel_d  = tYel_q;
    if (tmr.Prog_Sync) begin
      unique case (tmr.Time_Param_Sel)
        2'b00:   tBase_d = (tmr.Time_Value == 4'd0) ? BASE_RESET : tmr.Time_Value;
        2'b01:   tExt_d  = (tmr.Time_Value == 4'd0) ? EXT_RESET  : tmr.Time_Value;
        2'b10:   tYel_d  = (tmr.Time_Value == 4'd0) ? YEL_RESET  : tmr.Time_Value;
        default: begin
        end
      endcase
    end
  end

  // Countdown FSM next-state logic. A start request wins in either state and
  // discards any running count, so a restarted interval never expires and a
  // start issued while expired is high simply begins a fresh full second.
  // Expired defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;

    if (tmr.start_timer) begin
      state_d     = COUNT;
      prescaler_d = '0;
      remaining_d = duration;
    end else begin
      unique case (state_q)
        COUNT: begin
          if (secondTick) begin
            prescaler_d = '0;
            if (remaining_q <= 5'd1) begin
              remaining_d = 5'd0;
              state_d     = IDLE;
              expired_d   = 1'b1;
            end else begin
              remaining_d = remaining_q - 5'd1;
            end
          end else begin
            prescaler_d = prescaler_q + PW'(1);
          end
        end
        default: begin
          prescaler_d = '0;
          remaining_d = 5'd0;
        end
      endcase
    end
  end

  // State and parameter registers. Reset aborts any countdown without a
  // completion pulse and restores the default time parameters.
  always_ff @(posedge clk) begin
    if (!Reset_Sync_n) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      remaining_q <= 5'd0;
      expired_q   <= 1'b0;
      tBase_q     <= BASE_RESET;
      tExt_q      <= EXT_RESET;
      tYel_q      <= YEL_RESET;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      tBase_q     <= tBase_d;
      tExt_q      <= tExt_d;
      tYel_q      <= tYel_d;
    end
  end

  // Status outputs come straight from registers so the controller sees clean,
  // glitch-free signals.
  always_comb begin
    tmr.expired   = expired_q;
    tmr.busy      = (state_q == COUNT);
    tmr.remaining = remaining_q;
  end

endmodule

// File: tb/tb_light_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_light_interval_timer
//
// Purpose:
//   Self-checking bench for light_interval_timer. A driver issues directed and
//   random start/programming/reset stimulus and records, for every start, the
//   edge at which the expired pulse is due. A monitor samples the DUT just
//   after every rising edge, compares busy/remaining against the arithmetic
//   countdown of the active request and pops the expected pulse queue.
// ---------------------------------------------------------------------------
module tb_light_interval_timer;

  localparam int T     = 4;
  localparam int DEF_B = 6;
  localparam int DEF_E = 3;
  localparam int DEF_Y = 2;

  logic clk = 1'b0;
  logic rstN;

  light_interval_timer_if tif();

  light_interval_timer #(
    .TICKS_PER_SEC(T),
    .DEF_BASE(DEF_B),
    .DEF_EXT(DEF_E),
    .DEF_YEL(DEF_Y)
  ) dut (
    .clk(clk),
    .Reset_Sync_n(rstN),
    .tmr(tif.slave)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int edgeCount = 0;

  int params[3];
  bit active    = 1'b0;
  int startEdge = 0;
  int dur       = 0;
  int expectQ[$];

  // Default value of a time parameter by selector.
  function automatic int defaultOf(input int sel);
    case (sel)
      0:       return DEF_B;
      1:       return DEF_E;
      default: return DEF_Y;
    endcase
  endfunction

  // Duration in seconds of an interval code, from the model's parameters.
  function automatic int decode(input logic [1:0] iv);
    case (iv)
      2'b00:   return params[0];
      2'b01:   return params[1];
      2'b10:   return params[2];
      default: return 2 * params[0];
    endcase
  endfunction

  // One comparison: count it, report it when it does not hold.
  task automatic reportCheck(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, edgeCount, got, exp);
    end
  endtask

  // Compare DUT status against the model of the active countdown. A request
  // started at edge k with D seconds is busy for edges k..k+D*T-1 and shows
  // D minus the number of whole seconds elapsed; its pulse is due at k+D*T.
  task automatic checkOutput();
    int expRem;
    int expBusy;
    bit due;
    if (active && edgeCount < startEdge + dur * T) begin
      expBusy = 1;
      expRem  = dur - (edgeCount - startEdge) / T;
    end else begin
      expBusy = 0;
      expRem  = 0;
    end
    reportCheck("busy", int'(tif.busy), expBusy);
    reportCheck("remaining", int'(tif.remaining), expRem);
    due = (expectQ.size() > 0) && (expectQ[0] == edgeCount);
    if (due) begin
      reportCheck("expired_pulse", int'(tif.expired), 1);
      void'(expectQ.pop_front());
    end else begin
      reportCheck("expired_quiet", int'(tif.expired), 0);
    end
  endtask

  // Monitor: sample just after every rising edge, away from the driver.
  initial begin
    forever begin
      @(posedge clk);
      edgeCount++;
      #1;
      checkOutput();
    end
  end

  // Drive one cycle of stimulus from a falling edge and record the expected
  // response; the request is sampled at the next rising edge. Afterwards the
  // data inputs are scrambled to show they only matter on the strobe cycle.
  task automatic applyStimulus(input bit st, input logic [1:0] iv, input bit pg,
                               input logic [1:0] sel, input logic [3:0] val);
    int d;
    tif.start_timer    = st;
    tif.interval       = iv;
    tif.Prog_Sync      = pg;
    tif.Time_Param_Sel = sel;
    tif.Time_Value     = val;
    if (st) begin
      d = decode(iv);
      expectQ.delete();
      expectQ.push_back(edgeCount + 1 + d * T);
      active    = 1'b1;
      startEdge = edgeCount + 1;
      dur       = d;
    end
    if (pg && sel != 2'b11) begin
      params[sel] = (val == 4'd0) ? defaultOf(int'(sel)) : int'(val);
    end
    @(negedge clk);
    tif.start_timer    = 1'b0;
    tif.Prog_Sync      = 1'b0;
    tif.interval       = 2'($urandom);
    tif.Time_Param_Sel = 2'($urandom);
    tif.Time_Value     = 4'($urandom);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset for n cycles; the model drops any pending pulse and restores
  // the default parameters.
  task automatic applyReset(input int n);
    rstN = 1'b0;
    active = 1'b0;
    expectQ.delete();
    for (int i = 0; i < 3; i++) params[i] = defaultOf(i);
    repeat (n) @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    int r;
    rstN               = 1'b0;
    tif.start_timer    = 1'b0;
    tif.interval       = 2'b00;
    tif.Prog_Sync      = 1'b0;
    tif.Time_Param_Sel = 2'b00;
    tif.Time_Value     = 4'd0;
    for (int i = 0; i < 3; i++) params[i] = defaultOf(i);
    @(negedge clk);

    $display("[TB] reset and idle");
    applyReset(2);
    idleCycles(50);

    $display("[TB] tBASE countdown");
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    idleCycles(30);

    $display("[TB] 2*tBASE then chained tYEL in the expired cycle");
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 4'd0);
    idleCycles(48);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    idleCycles(20);

    $display("[TB] programming");
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 4'd5);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    idleCycles(25);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b00, 4'd9);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b00, 4'd0);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    idleCycles(30);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11, 4'd9);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    idleCycles(30);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    idleCycles(15);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    idleCycles(25);

    $display("[TB] start and write in the same cycle");
    applyStimulus(1'b1, 2'b01, 1'b1, 2'b01, 4'd7);
    idleCycles(15);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    idleCycles(35);

    $display("[TB] restart during count");
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    idleCycles(9);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    idleCycles(40);

    $display("[TB] reset mid-count");
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b00, 4'd11);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 4'd9);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    idleCycles(4);
    applyReset(1);
    idleCycles(100);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    idleCycles(30);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    idleCycles(15);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    idleCycles(12);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        applyStimulus(1'b1, 2'($urandom), ($urandom_range(0, 3) == 0),
                      2'($urandom), 4'($urandom));
      end else if (r < 60) begin
        applyStimulus(1'b0, 2'($urandom), 1'b1, 2'($urandom),
                      ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom));
      end else if (r < 95) begin
        idleCycles(int'($urandom_range(1, 40)));
      end else begin
        applyReset(int'($urandom_range(1, 3)));
      end
    end
    idleCycles(130);

    reportCheck("queue_drained", expectQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
